// File: rtl/alarme_pkg.sv
// Shared definitions for the intrusion alarm controller: state codes, zone bit positions, timer width.
package alarme_pkg;

    localparam int TMR_W = 16;

    localparam int ZB_P = 3;
    localparam int ZB_W = 2;
    localparam int ZB_M = 1;
    localparam int ZB_S = 0;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_e;

    function automatic logic is_armed(input state_e s);
        return (s == ST_EXIT) || (s == ST_ARMED) || (s == ST_ENTRY) || (s == ST_ALARM);
    endfunction

endpackage

// File: rtl/alarme_timer.sv
// Shared down-counter for the exit, entry and siren delays; expiry is combinational from the count.
// Latency: expired_o is high in the Nth cycle after a load of N. No backpressure.
// Saturates at zero; a load always wins over counting.
module alarme_timer
    import alarme_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The last held cycle is the one where the count reads 1, so a load of N holds N cycles.
    assign expired_o = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/alarme_ctrl.sv
// Intrusion alarm controller: arm/disarm, exit and entry delays, timed siren, latched trip memory.
// Latency: all outputs registered, one cycle after the sampled inputs. No backpressure.
// Optional door chime enabled by defining ALARME_CHIME_EN; otherwise chime is tied low.
module alarme_ctrl
    import alarme_pkg::*;
#(
    parameter int EXIT_DLY   = 16,
    parameter int ENTRY_DLY  = 16,
    parameter int SIREN_TIME = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic       disarm,
    input  logic       P,
    input  logic       W,
    input  logic       M,
    input  logic       S,
    output logic       A,
    output logic       armed,
    output logic [2:0] state,
    output logic [3:0] trip_zone,
    output logic       arm_fail,
    output logic       chime
);

    localparam logic [TMR_W-1:0] EXIT_V  = TMR_W'(EXIT_DLY);
    localparam logic [TMR_W-1:0] ENTRY_V = TMR_W'(ENTRY_DLY);
    localparam logic [TMR_W-1:0] SIREN_V = TMR_W'(SIREN_TIME);

    state_e           state_q, state_d;
    logic [3:0]       trip_q, trip_d;
    logic             a_q, armed_q;
    logic             arm_fail_q, arm_fail_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_exp;
    logic [3:0]       zones;

    always_comb begin
        zones       = '0;
        zones[ZB_P] = P;
        zones[ZB_W] = W;
        zones[ZB_M] = M;
        zones[ZB_S] = S;
    end

    alarme_timer u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

    always_comb begin
        state_d    = state_q;
        trip_d     = trip_q;
        arm_fail_d = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        if (S) begin
            // Panic/smoke overrides everything, including disarm, and restarts the siren.
            state_d      = ST_ALARM;
            trip_d[ZB_S] = 1'b1;
            tmr_load     = 1'b1;
            tmr_val      = SIREN_V;
        end else if (disarm) begin
            state_d = ST_DISARMED;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (arm) begin
                        if (P || W || M) begin
                            arm_fail_d = 1'b1;
                        end else begin
                            state_d  = ST_EXIT;
                            trip_d   = '0;
                            tmr_load = 1'b1;
                            tmr_val  = EXIT_V;
                        end
                    end
                end
                ST_EXIT: begin
                    if (tmr_exp) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (W || M) begin
                        state_d  = ST_ALARM;
                        trip_d   = trip_q | zones;
                        tmr_load = 1'b1;
                        tmr_val  = SIREN_V;
                    end else if (P) begin
                        state_d  = ST_ENTRY;
                        tmr_load = 1'b1;
                        tmr_val  = ENTRY_V;
                    end
                end
                ST_ENTRY: begin
                    if (W || M) begin
                        state_d  = ST_ALARM;
                        trip_d   = trip_q | zones;
                        tmr_load = 1'b1;
                        tmr_val  = SIREN_V;
                    end else if (tmr_exp) begin
                        state_d      = ST_ALARM;
                        trip_d[ZB_P] = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_val      = SIREN_V;
                    end
                end
                ST_ALARM: begin
                    if (tmr_exp) state_d = ST_ARMED;
                end
                default: state_d = ST_DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DISARMED;
            trip_q     <= '0;
            a_q        <= 1'b0;
            armed_q    <= 1'b0;
            arm_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trip_q     <= trip_d;
            a_q        <= (state_d == ST_ALARM);
            armed_q    <= is_armed(state_d);
            arm_fail_q <= arm_fail_d;
        end
    end

`ifdef ALARME_CHIME_EN
    logic p_q;
    logic chime_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= 1'b0;
            chime_q <= 1'b0;
        end else begin
            p_q     <= P;
            chime_q <= (state_q == ST_DISARMED) && P && !p_q;
        end
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

    assign state     = state_q;
    assign trip_zone = trip_q;
    assign A         = a_q;
    assign armed     = armed_q;
    assign arm_fail  = arm_fail_q;

endmodule
